// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : aes_pkg                                                        |
// | Purpose : Shared AES definitions for the iterative cipher: round-count   |
// |           helper, forward S-box table, GF(2^8) xtime, FSM encodings and  |
// |           the round-key width.                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package aes_pkg;

   localparam int RK_W  = 128;
   localparam int FSM_W = 2;

   localparam logic [FSM_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [FSM_W-1:0] ST_ROUND = 2'd1;
   localparam logic [FSM_W-1:0] ST_FINAL = 2'd2;
   localparam logic [FSM_W-1:0] ST_DONE  = 2'd3;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Number of rounds for a key of nk 32-bit words (4/6/8 -> 10/12/14).
   function automatic int nr_of(input int nk);
      return nk + 6;
   endfunction

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : aes_sbox                                                       |
// | Purpose : 8-bit combinational AES forward S-box lookup.                  |
// | Ports   : a_i  [7:0]  input byte                                         |
// |           s_o  [7:0]  substituted byte                                   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);

   assign s_o = SBOX[a_i];

endmodule
`default_nettype wire

// File: rtl/aes_cipher_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : aes_cipher_iter                                                |
// | Purpose : Iterative AES forward cipher, one round per clock. Takes the   |
// |           expanded key schedule (rk0 in the MSBs) and a 128-bit          |
// |           plaintext, produces the ciphertext nr clocks after accept.     |
// | Ports   : clk        rising-edge clock                                   |
// |           reset      asynchronous reset, active low                      |
// |           enable     start request, sampled while in_ready=1             |
// |           stateIn    plaintext, byte 0 in [127:120]                      |
// |           roundKeys  (nk+7)*128 key schedule, rk r at [(nr-r)*128 +:128] |
// |           stateOut   ciphertext, valid while done=1                      |
// |           in_ready   block can be accepted this cycle                    |
// |           done       ciphertext valid                                    |
// |           out_ready  (CIPHER_OUT_READY_EN only) downstream has taken the |
// |                      result; done/stateOut are held until it is 1        |
// | Macro   : CIPHER_OUT_READY_EN adds out_ready back-pressure; without it   |
// |           done is a single-cycle pulse.                                  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module aes_cipher_iter
   import aes_pkg::*;
#(
   parameter int nk = 4   // 4, 6 or 8 only
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [RK_W-1:0]         stateIn,
   input  logic [(nk+7)*RK_W-1:0]  roundKeys,
   output logic [RK_W-1:0]         stateOut,
   output logic                    in_ready,
   output logic                    done
`ifdef CIPHER_OUT_READY_EN
   ,
   input  logic                    out_ready
`endif
);

   localparam int         NR       = nr_of(nk);
   localparam logic [3:0] LAST_RND = 4'(NR - 1);

   logic [FSM_W-1:0] fsm_q, fsm_d;
   logic [RK_W-1:0]  state_q, state_d;
   logic [RK_W-1:0]  out_q, out_d;
   logic [3:0]       rnd_q, rnd_d;
   logic             done_q, done_d;

   logic             release_ok;   // DONE may hand back to the idle behaviour
   logic             accept;
   logic             do_round;
   logic             do_final;

   logic [RK_W-1:0]  rk0;
   logic [RK_W-1:0]  rk_cur;
   logic [RK_W-1:0]  sub_bytes;
   logic [RK_W-1:0]  shifted;
   logic [RK_W-1:0]  mixed;

`ifdef CIPHER_OUT_READY_EN
   assign release_ok = out_ready;
`else
   assign release_ok = 1'b1;
`endif

   // ---------------------------------------------------------------- helpers
   function automatic logic [RK_W-1:0] shift_rows(input logic [RK_W-1:0] s);
      logic [RK_W-1:0] o;
      o = '0;
      // Byte (row r, column c) takes the byte from column (c+r) mod 4.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [RK_W-1:0] mix_columns(input logic [RK_W-1:0] s);
      logic [RK_W-1:0] o;
      logic [7:0]      a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         // {02,03,01,01} circulant; 03*x = xtime(x) ^ x
         o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      return o;
   endfunction

   // --------------------------------------------------------------- datapath
   for (genvar i = 0; i < 16; i++) begin : g_sbox
      aes_sbox u_sbox (
         .a_i (state_q[8*i +: 8]),
         .s_o (sub_bytes[8*i +: 8])
      );
   end

   assign shifted = shift_rows(sub_bytes);
   assign mixed   = mix_columns(shifted);
   assign rk0     = roundKeys[(NR+1)*RK_W-1 -: RK_W];

   // Round key for the round now in flight (rnd_q = 1..NR).
   always_comb begin
      rk_cur = '0;
      for (int r = 1; r <= NR; r++) begin
         if (rnd_q == r[3:0]) begin
            rk_cur = roundKeys[(NR-r)*RK_W +: RK_W];
         end
      end
   end

   // -------------------------------------------------------- FSM: register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm_q <= ST_IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   // ------------------------------------------------------ FSM: next state
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         ST_IDLE:  if (accept) fsm_d = ST_ROUND;
         ST_ROUND: if (rnd_q == LAST_RND) fsm_d = ST_FINAL;
         ST_FINAL: fsm_d = ST_DONE;
         ST_DONE: begin
            if (accept) begin
               fsm_d = ST_ROUND;
            end else if (release_ok) begin
               fsm_d = ST_IDLE;
            end
         end
         default:  fsm_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------- FSM: outputs
   always_comb begin
      in_ready = 1'b0;
      do_round = 1'b0;
      do_final = 1'b0;
      case (fsm_q)
         ST_IDLE:  in_ready = 1'b1;
         ST_ROUND: do_round = 1'b1;
         ST_FINAL: do_final = 1'b1;
         ST_DONE:  in_ready = release_ok;
         default:  in_ready = 1'b0;
      endcase
   end

   assign accept = enable & in_ready;

   // ----------------------------------------------------- datapath next-state
   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      out_d   = out_q;
      done_d  = done_q;
      if (accept) begin
         state_d = stateIn ^ rk0;
         rnd_d   = 4'd1;
      end else if (do_round) begin
         state_d = mixed ^ rk_cur;
         rnd_d   = rnd_q + 4'd1;
      end
      // The last round skips MixColumns; its result goes straight to the output.
      if (do_final) begin
         out_d  = shifted ^ rk_cur;
         done_d = 1'b1;
      end else if ((fsm_q == ST_DONE) && release_ok) begin
         done_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= '0;
         out_q   <= '0;
         rnd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         rnd_q   <= rnd_d;
         done_q  <= done_d;
      end
   end

   assign stateOut = out_q;
   assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_cipher_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_aes_cipher_iter                                             |
// | Purpose : Self-checking bench for aes_cipher_iter at nk = 4, 6 and 8.    |
// |           Reference AES (S-box derived from GF(2^8) inverses, key        |
// |           expansion, cipher) is computed here from the algorithm.        |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_aes_cipher_iter;

   logic              clk = 1'b0;
   logic              reset;
   logic [2:0]        en;
   logic [2:0]        ir;
   logic [2:0]        dn;
   logic [2:0][127:0] pt;
   logic [2:0][127:0] so;
   logic [11*128-1:0] rk4;
   logic [13*128-1:0] rk6;
   logic [15*128-1:0] rk8;
`ifdef CIPHER_OUT_READY_EN
   logic              out_ready;
`endif

   int         n_cmp;
   int         n_fail;
   logic [7:0] ref_sbox [256];

   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

   always #5 clk = ~clk;

   aes_cipher_iter #(.nk(4)) u_dut4 (
      .clk(clk), .reset(reset), .enable(en[0]), .stateIn(pt[0]), .roundKeys(rk4),
      .stateOut(so[0]), .in_ready(ir[0]), .done(dn[0])
`ifdef CIPHER_OUT_READY_EN
      , .out_ready(out_ready)
`endif
   );
   aes_cipher_iter #(.nk(6)) u_dut6 (
      .clk(clk), .reset(reset), .enable(en[1]), .stateIn(pt[1]), .roundKeys(rk6),
      .stateOut(so[1]), .in_ready(ir[1]), .done(dn[1])
`ifdef CIPHER_OUT_READY_EN
      , .out_ready(out_ready)
`endif
   );
   aes_cipher_iter #(.nk(8)) u_dut8 (
      .clk(clk), .reset(reset), .enable(en[2]), .stateIn(pt[2]), .roundKeys(rk8),
      .stateOut(so[2]), .in_ready(ir[2]), .done(dn[2])
`ifdef CIPHER_OUT_READY_EN
      , .out_ready(out_ready)
`endif
   );

   // ------------------------------------------------------ reference model
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
      logic [7:0] t;
      t = v;
      for (int i = 0; i < n; i++) t = {t[6:0], t[7]};
      return t;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         ref_sbox[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {ref_sbox[w[31:24]], ref_sbox[w[23:16]], ref_sbox[w[15:8]], ref_sbox[w[7:0]]};
   endfunction

   // Key schedule, right-aligned, round key 0 in the most significant used bits.
   function automatic logic [1919:0] ref_keyexp(input logic [255:0] key, input int nk);
      logic [31:0]   w [60];
      logic [31:0]   tmp;
      logic [7:0]    rcon;
      logic [1919:0] v;
      int            tot;
      tot  = 4 * (nk + 7);
      v    = '0;
      rcon = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < tot; i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            tmp = sub_word(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      for (int i = 0; i < tot; i++) v[(tot-1-i)*32 +: 32] = w[i];
      return v;
   endfunction

   function automatic logic [127:0] ref_encrypt(input logic [127:0] p, input logic [1919:0] rk,
                                                input int nr);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] k, o;
      k = rk[nr*128 +: 128];
      for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[127-8*i -: 8];
      for (int rd = 1; rd <= nr; rd++) begin
         for (int i = 0; i < 16; i++) t[i] = ref_sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
         if (rd != nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
               s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
            end
         end
         k = rk[(nr-rd)*128 +: 128];
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   task automatic set_rk(input int d, input logic [1919:0] rkf);
      case (d)
         0:       rk4 = rkf[11*128-1:0];
         1:       rk6 = rkf[13*128-1:0];
         default: rk8 = rkf;
      endcase
   endtask

   // Counts edges until done rises on DUT d (0 = not within bound).
   task automatic wait_done(input int d, output int lat);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (dn[d] === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   // One block through DUT d with enable pulsed for a single edge.
   task automatic run_block(input int d, input logic [127:0] p, input logic [1919:0] rkf,
                            input logic [127:0] expct, input string name);
      int lat;
      set_rk(d, rkf);
      pt[d] = p;
      @(negedge clk); en[d] = 1'b1;
      @(posedge clk); #1;
      en[d] = 1'b0;
      pt[d] = {$urandom, $urandom, $urandom, $urandom};
      n_cmp++;
      if (ir[d] !== 1'b0) begin
         n_fail++; $display("FAIL %s busy_ready: got %b expected 0", name, ir[d]);
      end
      wait_done(d, lat);
      n_cmp++;
      if (lat != 10 + 2*d) begin
         n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, lat, 10 + 2*d);
      end
      n_cmp++;
      if (so[d] !== expct) begin
         n_fail++; $display("FAIL %s ciphertext: got %h expected %h", name, so[d], expct);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (dn[d] !== 1'b0) begin
         n_fail++; $display("FAIL %s done_pulse: got %b expected 0", name, dn[d]);
      end
      n_cmp++;
      if (so[d] !== expct) begin
         n_fail++; $display("FAIL %s held: got %h expected %h", name, so[d], expct);
      end
   endtask

   // ----------------------------------------------------------------- tests
   task automatic test_reset();
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (so[d] !== 128'h0 || dn[d] !== 1'b0 || ir[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: got out=%h done=%b ready=%b expected 0/0/1",
                     d, so[d], dn[d], ir[d]);
         end
      end
      @(negedge clk); reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (so[d] !== 128'h0 || dn[d] !== 1'b0 || ir[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_state dut%0d: got out=%h done=%b ready=%b expected 0/0/1",
                     d, so[d], dn[d], ir[d]);
         end
      end
   endtask

   task automatic test_kat();
      run_block(0, PT_C, ref_keyexp(KEY_C1, 4), CT_C1, "kat_c1");
      run_block(1, PT_C, ref_keyexp(KEY_C2, 6), CT_C2, "kat_c2");
      run_block(2, PT_C, ref_keyexp(KEY_C3, 8), CT_C3, "kat_c3");
   endtask

   task automatic test_back_to_back();
      int lat;
      set_rk(0, ref_keyexp(KEY_B, 4));
      pt[0] = PT_B;
      @(negedge clk); en[0] = 1'b1;
      @(posedge clk); #1;
      wait_done(0, lat);
      n_cmp++;
      if (lat != 10 || so[0] !== CT_B) begin
         n_fail++; $display("FAIL b2b_first: got lat=%0d out=%h expected 10 %h", lat, so[0], CT_B);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (dn[0] !== 1'b0 || ir[0] !== 1'b0 || so[0] !== CT_B) begin
         n_fail++;
         $display("FAIL b2b_accept: got done=%b ready=%b out=%h expected 0 0 %h", dn[0], ir[0], so[0], CT_B);
      end
      wait_done(0, lat);
      n_cmp++;
      if (lat != 10 || so[0] !== CT_B) begin
         n_fail++; $display("FAIL b2b_second: got lat=%0d out=%h expected 10 %h", lat, so[0], CT_B);
      end
      en[0] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort();
      int lat;
      int extra;
      set_rk(0, ref_keyexp(KEY_C1, 4));
      pt[0] = PT_C;
      @(negedge clk); en[0] = 1'b1;
      @(posedge clk); #1;
      en[0] = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (so[0] !== 128'h0 || dn[0] !== 1'b0 || ir[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_state: got out=%h done=%b ready=%b expected 0/0/1", so[0], dn[0], ir[0]);
      end
      n_cmp++;
      if (so[2] !== 128'h0) begin
         n_fail++; $display("FAIL abort_other: got %h expected 0", so[2]);
      end
      @(negedge clk); reset = 1'b1;
      // Restart, with enable pulses while busy that must be dropped.
      @(negedge clk); en[0] = 1'b1;
      @(posedge clk); #1;
      en[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1; en[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1; en[0] = 1'b0;
      lat = 0;
      wait_done(0, lat);
      n_cmp++;
      if (lat != 5 || so[0] !== CT_C1) begin
         n_fail++; $display("FAIL abort_restart: got lat=%0d out=%h expected 5 %h", lat, so[0], CT_C1);
      end
      extra = 0;
      repeat (16) begin
         @(posedge clk); #1;
         if (dn[0] === 1'b1) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_fail++; $display("FAIL busy_enable_queued: got %0d extra done expected 0", extra);
      end
   endtask

   task automatic test_random();
      int             d;
      logic [255:0]   key;
      logic [127:0]   p;
      logic [1919:0]  rkf;
      for (int it = 0; it < 24; it++) begin
         d   = $urandom_range(0, 2);
         key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         p   = {$urandom, $urandom, $urandom, $urandom};
         rkf = ref_keyexp(key, 4 + 2*d);
         run_block(d, p, rkf, ref_encrypt(p, rkf, 10 + 2*d), "random");
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
   endtask

`ifdef CIPHER_OUT_READY_EN
   task automatic test_out_ready();
      int            lat;
      logic [127:0]  p2;
      logic [1919:0] rkf;
      rkf = ref_keyexp(KEY_C1, 4);
      set_rk(0, rkf);
      pt[0] = PT_C;
      out_ready = 1'b0;
      @(negedge clk); en[0] = 1'b1;
      @(posedge clk); #1;
      en[0] = 1'b0;
      wait_done(0, lat);
      n_cmp++;
      if (lat != 10 || so[0] !== CT_C1) begin
         n_fail++; $display("FAIL hold_first: got lat=%0d out=%h expected 10 %h", lat, so[0], CT_C1);
      end
      p2 = {$urandom, $urandom, $urandom, $urandom};
      pt[0] = p2;
      for (int c = 0; c < 7; c++) begin
         en[0] = c[0];
         @(posedge clk); #1;
         n_cmp++;
         if (dn[0] !== 1'b1 || ir[0] !== 1'b0 || so[0] !== CT_C1) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: got done=%b ready=%b out=%h expected 1 0 %h",
                     c, dn[0], ir[0], so[0], CT_C1);
         end
      end
      @(negedge clk); en[0] = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      en[0] = 1'b0;
      n_cmp++;
      if (dn[0] !== 1'b0 || ir[0] !== 1'b0) begin
         n_fail++; $display("FAIL release_accept: got done=%b ready=%b expected 0 0", dn[0], ir[0]);
      end
      wait_done(0, lat);
      n_cmp++;
      if (lat != 10 || so[0] !== ref_encrypt(p2, rkf, 10)) begin
         n_fail++;
         $display("FAIL release_block: got lat=%0d out=%h expected 10 %h", lat, so[0], ref_encrypt(p2, rkf, 10));
      end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      reset  = 1'b0;
      en     = '0;
      pt     = '0;
      rk4    = '0;
      rk6    = '0;
      rk8    = '0;
`ifdef CIPHER_OUT_READY_EN
      out_ready = 1'b1;
`endif
      build_sbox();
      test_reset();
      test_kat();
      test_back_to_back();
      test_reset_abort();
      test_random();
`ifdef CIPHER_OUT_READY_EN
      test_out_ready();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
